// File: rtl/flash_sample_player.sv
// flash_sample_player: streams packed 16-bit PCM pairs from flash into the
// codec FIFO at a fractional playback rate with runtime attenuation.
module flash_sample_player #(
  parameter int NUM_WORDS = 1048576,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 23,
  parameter int FRAC_W    = 4,
  parameter int STEP_W    = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              pause,
  input  logic              loop,
  input  logic [STEP_W-1:0] rate_step,
  input  logic [3:0]        vol_shift,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  input  logic              write_ready,
  output logic              write_s,
  output logic [15:0]       writedata_left,
  output logic [15:0]       writedata_right,
  output logic [15:0]       sample_out,
  output logic              busy,
  output logic              done
);

  localparam int N_SAMP = 2 * NUM_WORDS;
  localparam int INT_W  = $clog2(N_SAMP);
  localparam int IDX_W  = INT_W + FRAC_W;
  localparam int MAX_W  = (IDX_W > STEP_W) ? IDX_W : STEP_W;
  localparam int SUM_W  = MAX_W + 1;

  localparam logic [SUM_W-1:0] LIMIT =
    SUM_W'(N_SAMP) << FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_WAIT_READY,
    S_SEND,
    S_ADV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [INT_W-1:0]  tag_q, tag_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       sample_q, sample_d;
  logic              done_q, done_d;

  logic [INT_W-1:0]  idx_int;
  logic [INT_W-1:0]  word_idx;
  logic              hit;
  logic [15:0]       half;
  logic [15:0]       shifted;
  logic [SUM_W-1:0]  sum;
  logic [15:0]       send_data;

  always_comb begin
    idx_int  = idx_q[IDX_W-1:FRAC_W];
    word_idx = idx_int >> 1;
    hit      = valid_q && (tag_q == word_idx);
    half     = idx_int[0] ? word_q[31:16]
                          : word_q[15:0];
    // arithmetic shift floors toward -inf
    shifted  = 16'($signed(half) >>> vol_shift);
    sum      = SUM_W'(idx_q) + SUM_W'(rate_step);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    tag_d    = tag_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !pause) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pause || !enable) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d = S_WAIT_READY;
        end else begin
          addr_d  = ADDR_W'(BASE_ADDR)
                  + ADDR_W'(word_idx);
          state_d = S_FETCH_REQ;
        end
      end
      S_FETCH_REQ: begin
        if (!flash_mem_waitrequest) begin
          state_d = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (flash_mem_readdatavalid) begin
          word_d  = flash_mem_readdata;
          tag_d   = word_idx;
          valid_d = 1'b1;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (write_ready) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        sample_d = shifted;
        if (!write_ready) begin
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (sum >= LIMIT) begin
          if (loop) begin
            idx_d   = IDX_W'(sum % LIMIT);
            state_d = S_CHECK;
          end else begin
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          idx_d   = IDX_W'(sum);
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  // data is live during SEND so vol_shift takes effect immediately
  always_comb begin
    send_data = (state_q == S_SEND) ? shifted
                                    : sample_q;
  end

  assign flash_mem_read    = (state_q == S_FETCH_REQ);
  assign flash_mem_address = addr_q;
  assign write_s           = (state_q == S_SEND);
  assign writedata_left    = send_data;
  assign writedata_right   = send_data;
  assign sample_out        = send_data;
  assign busy              = (state_q != S_IDLE) &&
                             (state_q != S_DONE);
  assign done              = done_q;

endmodule

// File: tb/tb_flash_sample_player.sv
// tb_flash_sample_player: scoreboard bench with flash and codec models
// for the fractional-rate sample player.
module tb_flash_sample_player;

  localparam int NW   = 4;
  localparam int BASE = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic        pause    = 1'b0;
  logic        loop     = 1'b0;
  logic [7:0]  rate_step = 8'd16;
  logic [3:0]  vol_shift = 4'd0;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest   = 1'b0;
  logic [31:0] flash_mem_readdata      = 32'd0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic        write_ready = 1'b1;
  logic        write_s;
  logic [15:0] writedata_left;
  logic [15:0] writedata_right;
  logic [15:0] sample_out;
  logic        busy;
  logic        done;

  flash_sample_player #(
    .NUM_WORDS(NW),
    .BASE_ADDR(BASE),
    .ADDR_W(23),
    .FRAC_W(4),
    .STEP_W(8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .enable(enable),
    .pause(pause),
    .loop(loop),
    .rate_step(rate_step),
    .vol_shift(vol_shift),
    .flash_mem_read(flash_mem_read),
    .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .write_ready(write_ready),
    .write_s(write_s),
    .writedata_left(writedata_left),
    .writedata_right(writedata_right),
    .sample_out(sample_out),
    .busy(busy),
    .done(done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem [NW] = '{
    32'h0002_0001, 32'h0004_0003,
    32'h0006_0005, 32'hFFFF_8000
  };

  logic [15:0] exp_q [$];
  int          exp_a [$];

  int n_err = 0;
  int n_chk = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_reads = 0;
  int hold = 0;
  int pend_cnt = 0;
  int drop_addr = -1;
  int wsel = 0;
  int wtarget = 0;
  logic [31:0] pend_data = 32'd0;
  bit dropped = 1'b0;
  bit inject_req = 1'b0;
  bit wok = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] samp(input int s);
    logic [31:0] w;
    w = mem[s >> 1];
    return s[0] ? w[31:16] : w[15:0];
  endfunction

  // reference: phase walks in 1/16-sample steps, one fetch per new word
  task automatic push_clip(input int rate, input int vol);
    int last;
    int s;
    logic signed [15:0] sv;
    last = -1;
    for (int ph = 0; (ph >> 4) < 2 * NW; ph += rate) begin
      s  = ph >> 4;
      sv = samp(s);
      exp_q.push_back(16'(sv >>> vol));
      if ((s >> 1) != last) begin
        last = s >> 1;
        exp_a.push_back(BASE + last);
      end
    end
  endtask

  // flash model: random waitrequest, fixed read latency
  always @(negedge CLOCK_50) begin
    flash_mem_readdatavalid = 1'b0;
    if (inject_req) begin
      inject_req = 1'b0;
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata = 32'h7777_7777;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = pend_data;
      end
    end
    flash_mem_waitrequest = ($urandom_range(0, 2) == 0);
    if (flash_mem_read && !flash_mem_waitrequest) begin
      n_reads++;
      if (exp_a.size() == 0)
        chk("unexp_read", 32'(flash_mem_address), 32'hFFFF_FFFF);
      else
        chk("read_addr", 32'(flash_mem_address),
            32'(exp_a.pop_front()));
      if (int'(flash_mem_address) == drop_addr) begin
        dropped = 1'b1;
      end else begin
        pend_cnt  = 2;
        pend_data = 32'h0;
        if (int'(flash_mem_address) >= BASE &&
            int'(flash_mem_address) < BASE + NW)
          pend_data = mem[int'(flash_mem_address) - BASE];
      end
    end
  end

  // codec model: accept, then drop ready for a random while
  always @(negedge CLOCK_50) begin
    logic [15:0] e;
    chk("rd_wr_excl", 32'(flash_mem_read & write_s), 32'd0);
    if (done) n_done++;
    if (write_s && write_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexp_write", 32'(writedata_left), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sample_left", 32'(writedata_left), 32'(e));
        chk("sample_right", 32'(writedata_right), 32'(e));
      end
      n_acc++;
      write_ready = 1'b0;
      hold = $urandom_range(0, 2);
    end else if (!write_ready) begin
      if (hold > 0) hold--;
      else write_ready = 1'b1;
    end
  end

  task automatic wait_until(input string tag,
                            input int which,
                            input int target,
                            input int budget);
    wsel    = which;
    wtarget = target;
    wok     = 1'b0;
    fork
      begin
        if (wsel == 0) wait (n_done >= wtarget);
        else if (wsel == 1) wait (n_acc >= wtarget);
        else wait (dropped);
        wok = 1'b1;
      end
      begin
        repeat (budget) @(negedge CLOCK_50);
      end
    join_any
    disable fork;
    chk(tag, 32'(wok), 32'd1);
  endtask

  task automatic run_clip(input string tag,
                          input int rate,
                          input int vol);
    int d0;
    rate_step = 8'(rate);
    vol_shift = 4'(vol);
    loop = 1'b0;
    push_clip(rate, vol);
    d0 = n_done;
    enable = 1'b1;
    wait_until({tag, "_done"}, 0, d0 + 1, 4000);
    repeat (6) @(negedge CLOCK_50);
    chk({tag, "_done_once"}, 32'(n_done), 32'(d0 + 1));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_samples_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_reads_left"}, 32'(exp_a.size()), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, 32'(flash_mem_read), 32'd0);
    chk({tag, "_addr"}, 32'(flash_mem_address), 32'd0);
    chk({tag, "_write_s"}, 32'(write_s), 32'd0);
    chk({tag, "_left"}, 32'(writedata_left), 32'd0);
    chk({tag, "_right"}, 32'(writedata_right), 32'd0);
    chk({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int r0;
    int d0;
    repeat (3) @(negedge CLOCK_50);
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    run_clip("normal", 16, 0);
    run_clip("half", 8, 0);
    run_clip("double", 32, 0);
    run_clip("vol6", 16, 6);

    // loop wrap, then pause in the middle of a codec handshake
    rate_step = 8'd16;
    vol_shift = 4'd0;
    loop = 1'b1;
    push_clip(16, 0);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_a.push_back(BASE);
    a0 = n_acc;
    enable = 1'b1;
    wait_until("loop_acc", 1, a0 + 10, 4000);
    pause = 1'b1;
    chk("ws_at_pause", 32'(write_s), 32'd1);
    r0 = n_reads;
    repeat (40) @(negedge CLOCK_50);
    chk("pause_acc", 32'(n_acc), 32'(a0 + 10));
    chk("pause_reads", 32'(n_reads), 32'(r0));
    chk("pause_busy", 32'(busy), 32'd0);
    chk("loop_samples_left", 32'(exp_q.size()), 32'd0);
    loop = 1'b0;
    for (int s = 2; s < 2 * NW; s++) exp_q.push_back(samp(s));
    for (int w = 1; w < NW; w++) exp_a.push_back(BASE + w);
    d0 = n_done;
    pause = 1'b0;
    wait_until("resume_done", 0, d0 + 1, 4000);
    repeat (4) @(negedge CLOCK_50);
    chk("resume_samples_left", 32'(exp_q.size()), 32'd0);
    chk("resume_reads_left", 32'(exp_a.size()), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // reset while the fetch of word 1 is outstanding
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_a.push_back(BASE);
    exp_a.push_back(BASE + 1);
    drop_addr = BASE + 1;
    dropped = 1'b0;
    enable = 1'b1;
    wait_until("drop_seen", 2, 0, 4000);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk_zero("midreset");
    reset = 1'b0;
    enable = 1'b0;
    inject_req = 1'b1;
    drop_addr = -1;
    repeat (5) @(negedge CLOCK_50);
    chk("stale_idle_busy", 32'(busy), 32'd0);
    chk("rst_samples_left", 32'(exp_q.size()), 32'd0);
    run_clip("after_reset", 16, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
